dm_hs: RTL



---
 rtl/dm_hs.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dm_hs.sv
// dm_hs: byte-addressable data memory with a valid/ready request channel,
// programmable wait states, sized/extended loads and a one-cycle response.
module dm_hs #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;

    localparam bit ZERO_LAT = (LATENCY == 0);

    localparam logic [3:0] CNT_INIT =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [3:0] cnt_q, cnt_d;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic accept;
    logic req_err;
    logic fire;
    logic use_live;

    logic                  a_we;
    logic [1:0]            a_size;
    logic                  a_uns;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [31:0]           a_wdata;
    logic [WA-1:0]         a_widx;

    logic [3:0]  be;
    logic [31:0] wd_al;
    logic [31:0] rword;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign accept = req_valid && req_ready;

    // Misaligned or illegal-size requests never touch memory.
    always_comb begin
        req_err = 1'b1;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Zero-latency accesses use the live request; otherwise the latched copy.
    assign use_live = (state_q == S_IDLE);

    assign a_we    = use_live ? req_we       : we_q;
    assign a_size  = use_live ? req_size     : size_q;
    assign a_uns   = use_live ? req_unsigned : uns_q;
    assign a_addr  = use_live ? req_addr     : addr_q;
    assign a_wdata = use_live ? req_wdata    : wdata_q;
    assign a_widx  = a_addr[ADDR_WIDTH-1:2];

    // Access edge: acceptance when zero-latency, else last wait cycle.
    assign fire = rst_n && (
        (accept && !req_err && ZERO_LAT) ||
        (state_q == S_WAIT && cnt_q == 4'd0));

    // FSM state register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: error and zero-latency requests skip WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err || ZERO_LAT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture request fields so inputs are free after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Byte enables and lane-replicated store data (little-endian).
    always_comb begin
        be    = 4'b0000;
        wd_al = a_wdata;
        unique case (a_size)
            2'b00: begin
                be    = 4'b0001 << a_addr[1:0];
                wd_al = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wd_al = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wd_al = a_wdata;
            end
            default: begin
                be    = 4'b0000;
                wd_al = a_wdata;
            end
        endcase
    end

    // Storage array: only selected lanes are written, never reset.
    always_ff @(posedge clk) begin
        if (fire && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[a_widx][8*i +: 8] <= wd_al[8*i +: 8];
                end
            end
        end
    end

    assign rword = mem_q[a_widx];

    // Lane select and sign/zero extension of load data.
    always_comb begin
        lane_b = rword[7:0];
        unique case (a_addr[1:0])
            2'd0: lane_b = rword[7:0];
            2'd1: lane_b = rword[15:8];
            2'd2: lane_b = rword[23:16];
            2'd3: lane_b = rword[31:24];
            default: lane_b = rword[7:0];
        endcase
        lane_h = a_addr[1] ? rword[31:16] : rword[15:0];
        ext    = rword;
        unique case (a_size)
            2'b00:   ext = {{24{~a_uns & lane_b[7]}}, lane_b};
            2'b01:   ext = {{16{~a_uns & lane_h[15]}}, lane_h};
            default: ext = rword;
        endcase
    end

    // Response registers hold until the next response is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else if (accept && req_err) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b1;
        end else if (fire) begin
            resp_rdata_q <= a_we ? 32'd0 : ext;
            resp_err_q   <= 1'b0;
        end
    end

endmodule
